align_controller: RTL

- Top-level sequencer for one alignment run: starts the systolic fill array, tracks the maximum cell score and its coordinates, clears and launches the backtrace unit, then reports completion.
- Sits between the host/test interface, the PE fill pipeline and the BRAM-backed backtrace unit.
- Generates the backtrace unit's enable, clear and start coordinates.

---
 rtl/align_if.sv | 37 +++
 rtl/align_controller.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/align_if.sv
// Handshake bundle between the alignment sequencer and its host, fill pipeline and backtrace unit.
// master = align_controller side, slave = the surrounding environment.
interface align_if #(
  parameter int len1        = 5,
  parameter int len2        = 5,
  parameter int score_width = 16
);
  localparam int ROW_W = $clog2(len1) + 1;
  localparam int COL_W = $clog2(len2) + 1;

  logic                          start;
  logic                          fill_enable;
  logic                          fill_score_valid;
  logic signed [score_width-1:0] fill_score;
  logic [ROW_W-1:0]              fill_row;
  logic [COL_W-1:0]              fill_col;
  logic                          fill_done;
  logic                          bt_clear;
  logic                          bt_enable;
  logic [ROW_W-1:0]              bt_startRow;
  logic [COL_W-1:0]              bt_startCol;
  logic                          bt_finished;
  logic                          busy;
  logic                          done;
  logic signed [score_width-1:0] max_score;
  logic                          error;

  modport master (
    input  start, fill_score_valid, fill_score, fill_row, fill_col, fill_done, bt_finished,
    output fill_enable, bt_clear, bt_enable, bt_startRow, bt_startCol, busy, done, max_score, error
  );

  modport slave (
    output start, fill_score_valid, fill_score, fill_row, fill_col, fill_done, bt_finished,
    input  fill_enable, bt_clear, bt_enable, bt_startRow, bt_startCol, busy, done, max_score, error
  );
endinterface

// File: rtl/align_controller.sv
// Alignment run sequencer: fill, max-score tracking, backtrace clear/load/launch, completion.
// Optional watchdog per FILL/BACKTRACE phase enabled by defining ALIGN_TIMEOUT_EN.
module align_controller #(
  parameter int len1           = 5,
  parameter int len2           = 5,
  parameter int score_width    = 16,
  parameter int timeout_cycles = 4096
) (
  input  logic     clk,
  input  logic     rst,
  align_if.master  bus
);
  localparam int ROW_W = $clog2(len1) + 1;
  localparam int COL_W = $clog2(len2) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_CLEAR, S_LOAD, S_BACKTRACE, S_DONE
  } state_e;

  state_e                        state_q, state_d;
  logic signed [score_width-1:0] max_score_q, max_score_d;
  logic [ROW_W-1:0]              start_row_q, start_row_d;
  logic [COL_W-1:0]              start_col_q, start_col_d;
  logic                          fill_enable_q, fill_enable_d;
  logic                          bt_clear_q, bt_clear_d;
  logic                          bt_enable_q, bt_enable_d;
  logic                          busy_q, busy_d;
  logic                          done_q, done_d;
  logic                          timeout_hit;

`ifdef ALIGN_TIMEOUT_EN
  localparam int CNT_W = $clog2(timeout_cycles) + 1;
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(timeout_cycles - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             error_q, error_d;

  // Expiry is flagged on the cycle that would bring the count to timeout_cycles.
  assign timeout_hit = (cnt_q == TIMEOUT_LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (state_q == S_FILL || state_q == S_BACKTRACE) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      error_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      error_q <= error_d;
    end
  end

  assign bus.error = error_q;
`else
  assign timeout_hit = 1'b0;
  assign bus.error   = 1'b0;
`endif

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d     = state_q;
    max_score_d = max_score_q;
    start_row_d = start_row_q;
    start_col_d = start_col_q;
`ifdef ALIGN_TIMEOUT_EN
    error_d     = error_q;
`endif

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d     = S_FILL;
          max_score_d = '0;
          start_row_d = '0;
          start_col_d = '0;
`ifdef ALIGN_TIMEOUT_EN
          error_d     = 1'b0;
`endif
        end
      end
      S_FILL: begin
        // Strict compare keeps the earliest cell on ties.
        if (bus.fill_score_valid && ($signed(bus.fill_score) > max_score_q)) begin
          max_score_d = bus.fill_score;
          start_row_d = bus.fill_row;
          start_col_d = bus.fill_col;
        end
        if (bus.fill_done) begin
          state_d = (max_score_d == '0) ? S_DONE : S_CLEAR;
        end else if (timeout_hit) begin
          state_d = S_DONE;
`ifdef ALIGN_TIMEOUT_EN
          error_d = 1'b1;
`endif
        end
      end
      S_CLEAR: state_d = S_LOAD;
      S_LOAD:  state_d = S_BACKTRACE;
      S_BACKTRACE: begin
        if (bus.bt_finished) begin
          state_d = S_DONE;
        end else if (timeout_hit) begin
          state_d = S_DONE;
`ifdef ALIGN_TIMEOUT_EN
          error_d = 1'b1;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so each one lands in a flop.
    fill_enable_d = (state_d == S_FILL);
    bt_clear_d    = (state_d == S_CLEAR);
    bt_enable_d   = (state_d == S_BACKTRACE);
    busy_d        = (state_d == S_FILL) || (state_d == S_CLEAR) ||
                    (state_d == S_LOAD) || (state_d == S_BACKTRACE);
    done_d        = (state_d == S_DONE);
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      max_score_q   <= '0;
      start_row_q   <= '0;
      start_col_q   <= '0;
      fill_enable_q <= 1'b0;
      bt_clear_q    <= 1'b0;
      bt_enable_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      max_score_q   <= max_score_d;
      start_row_q   <= start_row_d;
      start_col_q   <= start_col_d;
      fill_enable_q <= fill_enable_d;
      bt_clear_q    <= bt_clear_d;
      bt_enable_q   <= bt_enable_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign bus.fill_enable = fill_enable_q;
  assign bus.bt_clear    = bt_clear_q;
  assign bus.bt_enable   = bt_enable_q;
  assign bus.bt_startRow = start_row_q;
  assign bus.bt_startCol = start_col_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.max_score   = max_score_q;
endmodule
